// File: rtl/jk_ubus_master.sv
// UBUS initiator: accepts one command, arbitrates for the bus, runs the address and data
// phases, then returns a single response. Bus outputs are decoded from registered state.
module jk_ubus_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        size,
  output logic              read,
  output logic              write,
  output logic              bip,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic [7:0]        data_in,
  input  logic              wait_state,
  input  logic              error
);

  // Counter only needs to reach TIMEOUT-1: the terminal wait cycle is detected before increment.
  localparam int unsigned WcntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WcntW-1:0] WcntLast = WcntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StArb, StAddr, StData, StResp} state_e;

  state_e            state_q;
  logic              read_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic [2:0]        beat_q;
  logic [WcntW-1:0]  wcnt_q;
  logic              err_q;
  logic              tmo_q;

  logic [2:0] last_beat;
  logic       timeout_hit;
  logic       in_data;

  assign last_beat   = 3'((4'd1 << size_q) - 4'd1);
  assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WcntLast);
  assign in_data     = (state_q == StData);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      read_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            read_q  <= cmd_read;
            addr_q  <= cmd_addr;
            size_q  <= cmd_size;
            wdata_q <= cmd_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            state_q <= StArb;
          end
        end
        StArb: begin
          if (gnt) state_q <= StAddr;
        end
        StAddr: begin
          beat_q  <= '0;
          wcnt_q  <= '0;
          state_q <= StData;
        end
        StData: begin
          if (!wait_state) begin
            wcnt_q <= '0;
            if (read_q) rdata_q[{beat_q, 3'b000} +: 8] <= data_in;
            if (error) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else if (beat_q == last_beat) begin
              state_q <= StResp;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
            if (timeout_hit) begin
              err_q   <= 1'b1;
              tmo_q   <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    // Gated by reset so the port reads 0 while reset is held, not just after the first edge.
    cmd_ready   = reset && (state_q == StIdle);
    req         = (state_q == StArb);
    addr        = (state_q == StAddr) ? addr_q : '0;
    size        = (state_q == StAddr) ? size_q : '0;
    read        = (state_q == StAddr) && read_q;
    write       = (state_q == StAddr) && !read_q;
    bip         = in_data && (beat_q != last_beat);
    data_oe     = in_data && !read_q;
    data_out    = data_oe ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
    rsp_valid   = (state_q == StResp);
    rsp_rdata   = rsp_valid ? rdata_q : '0;
    rsp_error   = rsp_valid && err_q;
    rsp_timeout = rsp_valid && tmo_q;
  end

endmodule
